bcd_down_timer: RTL and testbench

Loadable multi-digit BCD down-counter for the reaction-timer datapath. It counts a preset BCD value down to zero, one step per `enb` strobe, and emits a one-cycle `done` pulse when the count reaches zero. It complements the existing up-counting BCD counter: this block generates the random pre-stimulus delay, and the up-counter measures the reaction.

---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_down_digit.sv | 41 ++++
 rtl/bcd_down_timer.sv | 90 +++++++++
 tb/tb_bcd_down_timer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD down-timer datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: clamped parallel load, decrement on borrow,
// combinational borrow out when the digit is at zero and asked to decrement.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    bcd_digit_t digit_reg;
    bcd_digit_t digit_next;
    bcd_digit_t load_clamped;

    assign load_clamped = (load_digit > BCD_MAX) ? BCD_MAX : load_digit;
    assign borrow_out   = borrow_in && (digit_reg == BCD_MIN);
    assign digit        = digit_reg;

    always_comb begin
        digit_next = digit_reg;
        if (load) begin
            digit_next = load_clamped;
        end else if (dec && borrow_in) begin
            digit_next = (digit_reg == BCD_MIN) ? BCD_MAX : digit_reg - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_reg <= BCD_MIN;
        end else begin
            digit_reg <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with IDLE/RUN control and a one-cycle
// done pulse when the countdown reaches zero (or on a zero-length start).
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enb,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  abort,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  zero,
    output logic                  done
);

    timer_state_t      state_reg;
    timer_state_t      state_next;
    logic              done_reg;
    logic              done_next;
    logic              load_en;
    logic              dec_en;
    logic              last_step;
    logic [DIGITS:0]   borrow;

    assign load_en   = (state_reg == IDLE) && load;
    assign dec_en    = (state_reg == RUN) && enb && !abort;
    assign last_step = (q == (4*DIGITS)'(1));
    assign zero      = (q == '0);
    assign running   = (state_reg == RUN);
    assign done      = done_reg;

    // Digit 0 always decrements on a step; higher digits only when borrowed from.
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_down_digit u_digit (
                .clk        (clk),
                .rst        (rst),
                .load       (load_en),
                .load_digit (load_val[4*gi +: 4]),
                .dec        (dec_en),
                .borrow_in  (borrow[gi]),
                .digit      (q[4*gi +: 4]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!load && start) begin
                    if (zero) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (enb && last_step) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
        end
    end

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: each step drives inputs after a clock edge
// and checks outputs 1 time unit after the following edge.
module tb_bcd_down_timer;

    logic        clk;
    logic        rst;
    logic        enb;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        abort;
    logic [15:0] q;
    logic        running;
    logic        zero;
    logic        done;

    int checks;
    int errors;

    bcd_down_timer #(.DIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .abort    (abort),
        .q        (q),
        .running  (running),
        .zero     (zero),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
        $display("check %-22s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        enb      = 1'b0;
        load     = 1'b0;
        load_val = 16'h0000;
        start    = 1'b0;
        abort    = 1'b0;

        // Reset state
        #2;
        check("rst_q",       q,              16'h0000);
        check("rst_zero",    16'(zero),      16'd1);
        check("rst_running", 16'(running),   16'd0);
        check("rst_done",    16'(done),      16'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_running", 16'(running), 16'd0);

        // Basic countdown from 3
        load = 1'b1; load_val = 16'h0003;
        tick();
        load = 1'b0;
        check("load3_q", q, 16'h0003);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start3_running", 16'(running), 16'd1);
        enb = 1'b1;
        tick();
        check("cnt_q2", q, 16'h0002);
        check("cnt_done_lo2", 16'(done), 16'd0);
        tick();
        check("cnt_q1", q, 16'h0001);
        tick();
        check("cnt_q0", q, 16'h0000);
        check("cnt_done_hi", 16'(done), 16'd1);
        check("cnt_running_lo", 16'(running), 16'd0);
        tick();
        enb = 1'b0;
        check("cnt_done_fall", 16'(done), 16'd0);
        check("cnt_q_stays0", q, 16'h0000);

        // Multi-digit borrow
        load = 1'b1; load_val = 16'h1000;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enb = 1'b1;
        tick();
        check("borrow_q0999", q, 16'h0999);
        tick();
        enb = 1'b0;
        check("borrow_q0998", q, 16'h0998);
        // load is ignored while running
        load = 1'b1; load_val = 16'h0123;
        tick();
        load = 1'b0;
        check("run_load_ignored", q, 16'h0998);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_running", 16'(running), 16'd0);
        check("abort_done", 16'(done), 16'd0);

        // Clamp and zero-length start
        load = 1'b1; load_val = 16'h00A5;
        tick();
        check("clamp_q", q, 16'h0095);
        load_val = 16'hFB9C;
        tick();
        check("clamp_all", q, 16'h9999);
        load_val = 16'h0000;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("zstart_done", 16'(done), 16'd1);
        check("zstart_running", 16'(running), 16'd0);
        tick();
        check("zstart_done_fall", 16'(done), 16'd0);
        check("zstart_running2", 16'(running), 16'd0);

        // Abort and priority
        load = 1'b1; load_val = 16'h0050;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enb = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("abort_pre_q", q, 16'h0045);
        abort = 1'b1;
        tick();
        abort = 1'b0; enb = 1'b0;
        check("abort_q_held", q, 16'h0045);
        check("abort_idle", 16'(running), 16'd0);
        check("abort_no_done", 16'(done), 16'd0);
        enb = 1'b1;
        tick();
        enb = 1'b0;
        check("idle_enb_ignored", q, 16'h0045);
        load = 1'b1; start = 1'b1; load_val = 16'h0007;
        tick();
        load = 1'b0; start = 1'b0;
        check("ldst_q", q, 16'h0007);
        check("ldst_running", 16'(running), 16'd0);
        check("ldst_done", 16'(done), 16'd0);
        tick();
        check("ldst_running2", 16'(running), 16'd0);

        // Reset mid-run
        load = 1'b1; load_val = 16'h0020;
        tick();
        load = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; enb = 1'b1;
        tick();
        tick();
        check("midrun_q", q, 16'h0018);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_q", q, 16'h0000);
        check("midrst_running", 16'(running), 16'd0);
        check("midrst_zero", 16'(zero), 16'd1);
        check("midrst_done", 16'(done), 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_hold_done", 16'(done), 16'd0);
        end
        rst = 1'b1;
        tick();
        enb = 1'b0;
        check("midrst_rel_q", q, 16'h0000);
        check("midrst_rel_running", 16'(running), 16'd0);
        check("midrst_rel_done", 16'(done), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
